// File: rtl/sdr_cmd_sched_if.sv
// sdr_cmd_sched_if
//   Bundles the requester handshake and the SDRAM command pins of the
//   command scheduler.
//   master : requester side (drives req_*, observes ready/done and the bus)
//   slave  : scheduler side (consumes req_*, drives ready/done and the bus)
//   req_valid/req_ready/req_wr/req_bank/req_row/req_col : request handshake
//   req_done                                            : READ/WRITE issued pulse
//   sdr_cs_n/sdr_ras_n/sdr_cas_n/sdr_we_n/sdr_ba/sdr_addr : SDRAM command pins
interface sdr_cmd_sched_if #(
  parameter int ROW_W = 13,
  parameter int COL_W = 9
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [1:0]       req_bank;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             req_done;

  logic             sdr_cs_n;
  logic             sdr_ras_n;
  logic             sdr_cas_n;
  logic             sdr_we_n;
  logic [1:0]       sdr_ba;
  logic [ROW_W-1:0] sdr_addr;

  modport master (
    output req_valid, req_wr, req_bank, req_row, req_col,
    input  req_ready, req_done,
    input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
  );

  modport slave (
    input  req_valid, req_wr, req_bank, req_row, req_col,
    output req_ready, req_done,
    output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
  );

endinterface

// File: rtl/sdr_cmd_sched.sv
// sdr_cmd_sched
//   Single-requester SDRAM command scheduler. Tracks the open row of each
//   bank (open-page policy), turns read/write requests into
//   PRECHARGE/ACTIVE/READ/WRITE sequences and inserts periodic AUTO_REFRESH.
//   All timing gaps are produced by the FSM itself, so commands are legal
//   by construction. Command pins are registered; NOP whenever idle.
// Ports
//   sdram_clk     : clock, rising edge
//   sdram_resetn  : asynchronous active-low reset
//   sdr_init_done : power-up init finished (only looked at in S_INIT)
//   bus           : slave modport of sdr_cmd_sched_if (request + SDRAM pins)
module sdr_cmd_sched #(
  parameter int ROW_W        = 13,
  parameter int COL_W        = 9,
  parameter int BURST_LENGTH = 1,
  parameter int TRCD         = 3,
  parameter int TRP          = 3,
  parameter int TRAS         = 6,
  parameter int TRFC         = 7,
  parameter int REF_INTERVAL = 780
) (
  input  logic           sdram_clk,
  input  logic           sdram_resetn,
  input  logic           sdr_init_done,
  sdr_cmd_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRE, S_ACT, S_XFR, S_PREALL, S_REF, S_WAIT
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  localparam int                TRAS_W   = $clog2(TRAS + 1);
  localparam logic [TRAS_W-1:0] TRAS_MAX = TRAS_W'(TRAS);
  localparam int                REF_W    = $clog2(REF_INTERVAL);
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REF_INTERVAL - 1);
  localparam int                WAIT_W   = 8;
  localparam logic [ROW_W-1:0]  ADDR_A10 = ROW_W'(1) << 10;

  state_t             state;
  state_t             wait_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [3:0]         cmd;
  logic [1:0]         ba_q;
  logic [ROW_W-1:0]   addr_q;
  logic               done_q;

  logic [3:0]         bank_open;
  logic [ROW_W-1:0]   bank_row [4];
  logic [TRAS_W-1:0]  tras_cnt [4];

  logic [REF_W-1:0]   ref_cnt;
  logic               ref_pending;
  logic               ref_wrap;

  logic               lat_wr;
  logic [1:0]         lat_bank;
  logic [ROW_W-1:0]   lat_row;
  logic [COL_W-1:0]   lat_col;

  logic [ROW_W-1:0]   col_addr;
  logic               tras_ok_all;

  assign bus.sdr_cs_n  = cmd[3];
  assign bus.sdr_ras_n = cmd[2];
  assign bus.sdr_cas_n = cmd[1];
  assign bus.sdr_we_n  = cmd[0];
  assign bus.sdr_ba    = ba_q;
  assign bus.sdr_addr  = addr_q;
  assign bus.req_done  = done_q;

  // Requests are only taken from idle, and a pending refresh blocks them.
  assign bus.req_ready = (state == S_IDLE) && !ref_pending;

  // Column goes out zero-extended; A10 must stay low so no auto-precharge.
  // The all-bank precharge may only fire once every open bank has met TRAS.
  always_comb begin
    col_addr              = '0;
    col_addr[COL_W-1:0]   = lat_col;
    col_addr[10]          = 1'b0;
    tras_ok_all           = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (bank_open[b] && (tras_cnt[b] != TRAS_MAX)) begin
        tras_ok_all = 1'b0;
      end
    end
  end

  // Refresh timer runs once init is complete. A wrap while a refresh is
  // still pending simply keeps it pending; a wrap coinciding with the
  // AUTO_REFRESH cycle wins so that request is not dropped.
  assign ref_wrap = (state != S_INIT) && (ref_cnt == REF_LAST);

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (state != S_INIT) begin
        ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      end
      if (ref_wrap) begin
        ref_pending <= 1'b1;
      end else if (state == S_REF) begin
        ref_pending <= 1'b0;
      end
    end
  end

  // Per-bank ACTIVE age, saturating at TRAS. S_ACT always issues ACTIVE in
  // the same cycle, so being in S_ACT is the restart condition.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      for (int b = 0; b < 4; b++) begin
        tras_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if ((state == S_ACT) && (lat_bank == 2'(b))) begin
          tras_cnt[b] <= '0;
        end else if (tras_cnt[b] != TRAS_MAX) begin
          tras_cnt[b] <= tras_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Main scheduler. Each command state issues its command on its own edge,
  // then parks in S_WAIT for the required number of NOP cycles before
  // moving on; wait_next holds where to go afterwards.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state     <= S_INIT;
      wait_next <= S_IDLE;
      wait_cnt  <= '0;
      cmd       <= CMD_NOP;
      ba_q      <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      bank_open <= '0;
      for (int b = 0; b < 4; b++) begin
        bank_row[b] <= '0;
      end
      lat_wr    <= 1'b0;
      lat_bank  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
    end else begin
      cmd    <= CMD_NOP;
      ba_q   <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
      case (state)
        S_INIT: begin
          if (sdr_init_done) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (ref_pending) begin
            state <= (|bank_open) ? S_PREALL : S_REF;
          end else if (bus.req_valid) begin
            lat_wr   <= bus.req_wr;
            lat_bank <= bus.req_bank;
            lat_row  <= bus.req_row;
            lat_col  <= bus.req_col;
            if (!bank_open[bus.req_bank]) begin
              state <= S_ACT;
            end else if (bank_row[bus.req_bank] == bus.req_row) begin
              state <= S_XFR;
            end else begin
              state <= S_PRE;
            end
          end
        end
        S_PRE: begin
          if (tras_cnt[lat_bank] == TRAS_MAX) begin
            cmd                 <= CMD_PRE;
            ba_q                <= lat_bank;
            bank_open[lat_bank] <= 1'b0;
            if (TRP > 1) begin
              state     <= S_WAIT;
              wait_cnt  <= WAIT_W'(TRP - 1);
              wait_next <= S_ACT;
            end else begin
              state <= S_ACT;
            end
          end
        end
        S_ACT: begin
          cmd                 <= CMD_ACT;
          ba_q                <= lat_bank;
          addr_q              <= lat_row;
          bank_open[lat_bank] <= 1'b1;
          bank_row[lat_bank]  <= lat_row;
          if (TRCD > 1) begin
            state     <= S_WAIT;
            wait_cnt  <= WAIT_W'(TRCD - 1);
            wait_next <= S_XFR;
          end else begin
            state <= S_XFR;
          end
        end
        S_XFR: begin
          cmd    <= lat_wr ? CMD_WRITE : CMD_READ;
          ba_q   <= lat_bank;
          addr_q <= col_addr;
          done_q <= 1'b1;
          if (BURST_LENGTH > 1) begin
            state     <= S_WAIT;
            wait_cnt  <= WAIT_W'(BURST_LENGTH - 1);
            wait_next <= S_IDLE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREALL: begin
          if (tras_ok_all) begin
            cmd       <= CMD_PRE;
            addr_q    <= ADDR_A10;
            bank_open <= '0;
            if (TRP > 1) begin
              state     <= S_WAIT;
              wait_cnt  <= WAIT_W'(TRP - 1);
              wait_next <= S_REF;
            end else begin
              state <= S_REF;
            end
          end
        end
        S_REF: begin
          cmd <= CMD_REF;
          if (TRFC > 1) begin
            state     <= S_WAIT;
            wait_cnt  <= WAIT_W'(TRFC - 1);
            wait_next <= S_IDLE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt <= WAIT_W'(1)) begin
            state <= wait_next;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
